pwm_ramp_ctrl: RTL and testbench

Command-driven sequencer for the 8-bit PWM unit. It accepts a target duty, range, step and enable command over a valid/ready handshake. It then drives pwm_value, pwm_range and pwm_en, ramping the duty toward the target by one step per PWM period so that duty changes are glitch-free and aligned to period boundaries. It sits between the register/host logic and the PWM unit and consumes the unit's pwm_period pulse.

---
 rtl/pwm_ramp_ctrl_if.sv | 31 +++
 rtl/pwm_ramp_ctrl.sv | 130 +++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel into pwm_ramp_ctrl: valid/ready handshake carrying the
// target duty, PWM range, ramp step and enable request.
interface pwm_ramp_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_target;
    logic [WIDTH-1:0]  cmd_range;
    logic [STEP_W-1:0] cmd_step;
    logic              cmd_enable;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_range,
        output cmd_step,
        output cmd_enable,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_range,
        input  cmd_step,
        input  cmd_enable,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for the PWM unit: walks pwm_value toward a commanded duty
// one step per PWM period so duty and range only change on period edges.
// Ports: clk, reset (sync, active-high), cmd (slave command channel),
// pwm_period (end-of-period pulse), pwm_value/pwm_range/pwm_en (to PWM unit),
// busy (ramp in progress), done (one-cycle completion pulse).
module pwm_ramp_ctrl #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    pwm_ramp_ctrl_if.slave   cmd,
    input  logic             pwm_period,
    output logic [WIDTH-1:0] pwm_value,
    output logic [WIDTH-1:0] pwm_range,
    output logic             pwm_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t state;

    // Command fields captured at acceptance; the range is held back until
    // the first period edge so a running PWM never sees a mid-period change.
    logic [WIDTH-1:0]  sh_target;
    logic [WIDTH-1:0]  sh_range;
    logic [STEP_W-1:0] sh_step;
    logic              sh_disable;

    logic              accept;
    logic [WIDTH-1:0]  sat_target;
    logic              up;
    logic [WIDTH:0]    diff;
    logic [WIDTH:0]    step_ext;
    logic [WIDTH-1:0]  step_n;
    logic              arrive;

    assign cmd.cmd_ready = (state == IDLE) & ~reset;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign busy          = (state == RAMP);

    // A disable request always ramps to zero; otherwise the duty is
    // clamped so it can never exceed the range it will run under.
    always_comb begin
        sat_target = '0;
        if (cmd.cmd_enable) begin
            if (cmd.cmd_target > cmd.cmd_range)
                sat_target = cmd.cmd_range;
            else
                sat_target = cmd.cmd_target;
        end
    end

    // Distance is computed one bit wider so the subtraction cannot wrap.
    assign up       = sh_target > pwm_value;
    assign diff     = up ? ({1'b0, sh_target} - {1'b0, pwm_value})
                         : ({1'b0, pwm_value} - {1'b0, sh_target});
    assign step_ext = (WIDTH+1)'(sh_step);
    assign step_n   = WIDTH'(sh_step);
    assign arrive   = (sh_step == '0) | (diff <= step_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pwm_value  <= '0;
            pwm_range  <= '1;
            pwm_en     <= 1'b0;
            done       <= 1'b0;
            sh_target  <= '0;
            sh_range   <= '0;
            sh_step    <= '0;
            sh_disable <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sh_target  <= sat_target;
                        sh_range   <= cmd.cmd_range;
                        sh_step    <= cmd.cmd_step;
                        sh_disable <= ~cmd.cmd_enable;
                        if (!pwm_en && !cmd.cmd_enable) begin
                            // Already off: nothing to ramp.
                            done <= 1'b1;
                        end else begin
                            state <= RAMP;
                            if (!pwm_en) begin
                                // Start from zero duty; no running
                                // period to protect, so range goes now.
                                pwm_range <= cmd.cmd_range;
                                pwm_value <= '0;
                                pwm_en    <= 1'b1;
                            end
                        end
                    end
                end
                RAMP: begin
                    if (pwm_period) begin
                        pwm_range <= sh_range;
                        if (arrive) begin
                            pwm_value <= sh_target;
                            done      <= 1'b1;
                            state     <= IDLE;
                            if (sh_disable)
                                pwm_en <= 1'b0;
                        end else if (up) begin
                            pwm_value <= pwm_value + step_n;
                        end else begin
                            pwm_value <= pwm_value - step_n;
                        end
                    end
                end
            endcase
        end
    end

    a_done_not_busy: assert property (
        @(posedge clk) disable iff (reset) !(done && busy)
    );

    a_value_in_range: assert property (
        @(posedge clk) disable iff (reset) done |-> (pwm_value <= pwm_range)
    );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: vector table, corner sequences and random
// traffic against a queue-based reference model of the ramp.
module tb_pwm_ramp_ctrl;

    logic       clk;
    logic       reset;
    logic       pwm_period;
    logic [7:0] pwm_value;
    logic [7:0] pwm_range;
    logic       pwm_en;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_bad;

    pwm_ramp_ctrl_if #(.WIDTH(8), .STEP_W(4)) bus ();

    pwm_ramp_ctrl #(.WIDTH(8), .STEP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (bus.slave),
        .pwm_period (pwm_period),
        .pwm_value  (pwm_value),
        .pwm_range  (pwm_range),
        .pwm_en     (pwm_en),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: on acceptance the whole list of per-period duty
    // values is precomputed; each period edge consumes one entry.
    int m_val;
    int m_rng;
    bit m_en;
    bit m_busy;
    bit m_done;
    int m_shr;
    bit m_dis;
    int q[$];

    bit d_rst;
    bit d_v;
    int d_tgt;
    int d_rng;
    int d_stp;
    bit d_ena;
    bit d_per;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_busy && !d_rst;
    endfunction

    task automatic model_update();
        int t;
        int v;
        int start;
        if (d_rst) begin
            m_val = 0; m_rng = 255; m_en = 0;
            m_busy = 0; m_done = 0; m_shr = 0; m_dis = 0;
            q.delete();
            return;
        end
        m_done = 0;
        if (!m_busy) begin
            if (d_v) begin
                t = d_ena ? ((d_tgt < d_rng) ? d_tgt : d_rng) : 0;
                if (!m_en && !d_ena) begin
                    m_done = 1;
                end else begin
                    start = m_en ? m_val : 0;
                    m_busy = 1;
                    m_shr = d_rng;
                    m_dis = !d_ena;
                    if (!m_en) begin
                        m_rng = d_rng; m_val = 0; m_en = 1;
                    end
                    q.delete();
                    v = start;
                    do begin
                        if (d_stp == 0 || (t > v ? t - v : v - t) <= d_stp)
                            v = t;
                        else if (t > v)
                            v = v + d_stp;
                        else
                            v = v - d_stp;
                        q.push_back(v);
                    end while (v != t);
                end
            end
        end else if (d_per) begin
            m_rng = m_shr;
            m_val = q.pop_front();
            if (q.size() == 0) begin
                m_busy = 0;
                m_done = 1;
                if (m_dis) m_en = 0;
            end
        end
    endtask

    task automatic drive(bit rst, bit v, int tgt, int rng, int stp,
                         bit ena, bit per);
        d_rst = rst; d_v = v; d_tgt = tgt; d_rng = rng;
        d_stp = stp; d_ena = ena; d_per = per;
        reset          = rst;
        bus.cmd_valid  = v;
        bus.cmd_target = 8'(tgt);
        bus.cmd_range  = 8'(rng);
        bus.cmd_step   = 4'(stp);
        bus.cmd_enable = ena;
        pwm_period     = per;
        #1;
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("value", pwm_value, m_val);
        chk("range", pwm_range, m_rng);
        chk("en",    pwm_en,    m_en);
        chk("busy",  busy,      m_busy);
        chk("done",  done,      m_done);
    endtask

    typedef struct {
        bit rst; bit v; int tgt; int rng; int stp; bit ena; bit per;
        bit rdy; int val; int rg; bit en; bit bsy; bit dn;
    } vec_t;

    vec_t tbl[18];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1, 0, 0, 0, 0, 0, 0);

        tbl[0]  = '{1,0,  0,  0, 0,0,0, 0,  0,255,0,0,0};
        tbl[1]  = '{1,0,  0,  0, 0,0,0, 0,  0,255,0,0,0};
        tbl[2]  = '{1,0,  0,  0, 0,0,0, 0,  0,255,0,0,0};
        tbl[3]  = '{0,0,  0,  0, 0,0,0, 1,  0,255,0,0,0};
        tbl[4]  = '{0,1, 40,100,10,1,0, 1,  0,100,1,1,0};
        tbl[5]  = '{0,0,  0,  0, 0,0,0, 0,  0,100,1,1,0};
        tbl[6]  = '{0,0,  0,  0, 0,0,1, 0, 10,100,1,1,0};
        tbl[7]  = '{0,0,  0,  0, 0,0,1, 0, 20,100,1,1,0};
        tbl[8]  = '{0,0,  0,  0, 0,0,1, 0, 30,100,1,1,0};
        tbl[9]  = '{0,0,  0,  0, 0,0,1, 0, 40,100,1,0,1};
        tbl[10] = '{0,0,  0,  0, 0,0,0, 1, 40,100,1,0,0};
        tbl[11] = '{0,1, 35,100, 4,1,0, 1, 40,100,1,1,0};
        tbl[12] = '{0,0,  0,  0, 0,0,1, 0, 36,100,1,1,0};
        tbl[13] = '{0,0,  0,  0, 0,0,1, 0, 35,100,1,0,1};
        tbl[14] = '{0,1,  0,100, 0,0,0, 1, 35,100,1,1,0};
        tbl[15] = '{0,0,  0,  0, 0,0,1, 0,  0,100,0,0,1};
        tbl[16] = '{0,1,  0,100, 0,0,0, 1,  0,100,0,0,1};
        tbl[17] = '{0,0,  0,  0, 0,0,0, 1,  0,100,0,0,0};

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].tgt, tbl[i].rng,
                  tbl[i].stp, tbl[i].ena, tbl[i].per);
            chk($sformatf("tbl%0d_ready", i), bus.cmd_ready, tbl[i].rdy);
            advance();
            chk($sformatf("tbl%0d_value", i), pwm_value, tbl[i].val);
            chk($sformatf("tbl%0d_range", i), pwm_range, tbl[i].rg);
            chk($sformatf("tbl%0d_en", i),    pwm_en,    tbl[i].en);
            chk($sformatf("tbl%0d_busy", i),  busy,      tbl[i].bsy);
            chk($sformatf("tbl%0d_done", i),  done,      tbl[i].dn);
        end

        // Saturated jump, pulse in the accept cycle, held-off command.
        drive(0, 1, 200, 150, 0, 1, 1);
        chk("sat_ready", bus.cmd_ready, 1);
        advance();
        chk("sat_noskip", pwm_value, 0);
        chk("sat_range", pwm_range, 150);
        check_model();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 50, 150, 5, 1, 0);
            chk("bp_ready", bus.cmd_ready, 0);
            advance();
            chk("bp_hold", pwm_value, 0);
            check_model();
        end
        drive(0, 1, 50, 150, 5, 1, 1);
        chk("bp_ready_last", bus.cmd_ready, 0);
        advance();
        chk("sat_value", pwm_value, 150);
        chk("sat_done", done, 1);
        check_model();
        drive(0, 1, 50, 150, 5, 1, 0);
        chk("bp_accept", bus.cmd_ready, 1);
        advance();
        chk("bp_busy", busy, 1);
        check_model();
        for (int i = 0; i < 100 && m_busy; i++) begin
            drive(0, 0, 0, 0, 0, 0, i[0]);
            chk("down_ready", bus.cmd_ready, m_ready());
            advance();
            check_model();
        end
        chk("down_end_busy", busy, 0);
        chk("down_end_value", pwm_value, 50);

        // Reset in the middle of a ramp.
        drive(1, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 1, 40, 100, 10, 1, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1);
        advance();
        chk("mid_value", pwm_value, 20);
        drive(1, 0, 0, 0, 0, 0, 1);
        advance();
        chk("rst_value", pwm_value, 0);
        chk("rst_range", pwm_range, 255);
        chk("rst_en", pwm_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        advance();
        chk("rst_no_done", done, 0);
        check_model();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 255),
                  $urandom_range(0, 255),
                  $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1);
            chk("rnd_ready", bus.cmd_ready, m_ready());
            advance();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
